// File: rtl/fetch_stall_pipe.sv
// Front end of the pipeline: PC, IF/ID and ID/EX control registers.
// Hazard-unit holds/bubbles and ID branch redirects are applied here, with saturating debug counters.
module fetch_stall_pipe #(
    parameter int unsigned   ADDR_W   = 32,
    parameter int unsigned   INSTR_W  = 32,
    parameter int unsigned   CTRL_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned   CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pc_write,
    input  logic                if_id_write,
    input  logic                control_mux_select,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_target,
    input  logic [INSTR_W-1:0]  imem_instr,
    input  logic [CTRL_W-1:0]   id_ctrl,
    output logic [ADDR_W-1:0]   pc,
    output logic [INSTR_W-1:0]  if_id_instr,
    output logic [ADDR_W-1:0]   if_id_pc4,
    output logic                if_id_valid,
    output logic [CTRL_W-1:0]   id_ex_ctrl,
    output logic                id_ex_valid,
    output logic [CNT_W-1:0]    stall_count,
    output logic [CNT_W-1:0]    flush_count
);

    logic              accept;
    logic [ADDR_W-1:0] pc_plus4;

    // A stalled ID instruction has unready operands, so it may not redirect.
    assign accept   = branch_taken & if_id_valid & ~control_mux_select;
    assign pc_plus4 = pc + ADDR_W'(4);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            if_id_instr <= '0;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
            id_ex_ctrl  <= '0;
            id_ex_valid <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (accept)
                pc <= branch_target;
            else if (pc_write)
                pc <= pc_plus4;

            // Flush keeps if_id_pc4 so only the instruction slot is killed.
            if (accept) begin
                if_id_instr <= '0;
                if_id_valid <= 1'b0;
            end else if (if_id_write) begin
                if_id_instr <= imem_instr;
                if_id_pc4   <= pc_plus4;
                if_id_valid <= 1'b1;
            end

            if (control_mux_select || !if_id_valid) begin
                id_ex_ctrl  <= '0;
                id_ex_valid <= 1'b0;
            end else begin
                id_ex_ctrl  <= id_ctrl;
                id_ex_valid <= 1'b1;
            end

            if (control_mux_select && (stall_count != {CNT_W{1'b1}}))
                stall_count <= stall_count + CNT_W'(1);
            if (accept && (flush_count != {CNT_W{1'b1}}))
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fetch_stall_pipe.sv
// Directed bench for fetch_stall_pipe: fetch, load-use stall, branch flush, stall+branch, reset.
// A second instance with a high RESET_PC and 2-bit counters covers PC wrap and counter saturation.
module tb_fetch_stall_pipe;

    logic        clk = 1'b0;
    logic        rst_n, pc_write, if_id_write, control_mux_select, branch_taken;
    logic [31:0] branch_target, imem_instr;
    logic [15:0] id_ctrl;
    logic [31:0] pc, if_id_instr, if_id_pc4;
    logic        if_id_valid, id_ex_valid;
    logic [15:0] id_ex_ctrl, stall_count, flush_count;

    logic        w_rst_n, w_mux;
    logic [31:0] w_pc, w_if_id_instr, w_if_id_pc4;
    logic        w_if_id_valid, w_id_ex_valid;
    logic [15:0] w_id_ex_ctrl;
    logic [1:0]  w_stall_count, w_flush_count;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Instruction memory returns a pc-tagged word; decoder control is derived from IF/ID.
    assign imem_instr = pc | 32'h1300_0000;
    assign id_ctrl    = if_id_instr[15:0] ^ 16'hC000;

    fetch_stall_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .if_id_write(if_id_write),
        .control_mux_select(control_mux_select), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_instr(imem_instr), .id_ctrl(id_ctrl),
        .pc(pc), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
        .id_ex_ctrl(id_ex_ctrl), .id_ex_valid(id_ex_valid),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    fetch_stall_pipe #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(2)) u_wrap (
        .clk(clk), .rst_n(w_rst_n), .pc_write(1'b1), .if_id_write(1'b1),
        .control_mux_select(w_mux), .branch_taken(1'b0),
        .branch_target(32'h0), .imem_instr(32'h0000_0001), .id_ctrl(16'h0005),
        .pc(w_pc), .if_id_instr(w_if_id_instr), .if_id_pc4(w_if_id_pc4), .if_id_valid(w_if_id_valid),
        .id_ex_ctrl(w_id_ex_ctrl), .id_ex_valid(w_id_ex_valid),
        .stall_count(w_stall_count), .flush_count(w_flush_count)
    );

    task automatic applyStimulus(input logic rst, input logic pw, input logic iw,
                                 input logic mux, input logic br, input logic [31:0] tgt);
        rst_n              = rst;
        pc_write           = pw;
        if_id_write        = iw;
        control_mux_select = mux;
        branch_taken       = br;
        branch_target      = tgt;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkMain(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                             input logic [31:0] e_pc4, input logic e_ifv, input logic [15:0] e_ctrl,
                             input logic e_exv, input logic [15:0] e_stall, input logic [15:0] e_flush);
        checkOutput({tag, ".pc"},          pc,                  e_pc);
        checkOutput({tag, ".if_id_instr"}, if_id_instr,         e_instr);
        checkOutput({tag, ".if_id_pc4"},   if_id_pc4,           e_pc4);
        checkOutput({tag, ".if_id_valid"}, {31'b0, if_id_valid}, {31'b0, e_ifv});
        checkOutput({tag, ".id_ex_ctrl"},  {16'b0, id_ex_ctrl}, {16'b0, e_ctrl});
        checkOutput({tag, ".id_ex_valid"}, {31'b0, id_ex_valid}, {31'b0, e_exv});
        checkOutput({tag, ".stall_count"}, {16'b0, stall_count}, {16'b0, e_stall});
        checkOutput({tag, ".flush_count"}, {16'b0, flush_count}, {16'b0, e_flush});
    endtask

    task automatic checkWrap(input string tag, input logic [31:0] e_pc, input logic [1:0] e_stall);
        checkOutput({tag, ".pc"},          w_pc,                   e_pc);
        checkOutput({tag, ".stall_count"}, {30'b0, w_stall_count}, {30'b0, e_stall});
    endtask

    initial begin
        w_rst_n = 1'b1;
        w_mux   = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        #2;

        stepClock();
        checkMain("reset", 32'h0, 32'h0, 32'h0, 1'b0, 16'h0, 1'b0, 16'd0, 16'd0);

        // First cycle after reset: IF/ID invalid, so the branch must be ignored.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h40);
        stepClock();
        checkMain("run1", 32'h4, 32'h1300_0000, 32'h4, 1'b1, 16'h0, 1'b0, 16'd0, 16'd0);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        stepClock();
        checkMain("run2", 32'h8, 32'h1300_0004, 32'h8, 1'b1, 16'hC000, 1'b1, 16'd0, 16'd0);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        stepClock();
        checkMain("stall", 32'h8, 32'h1300_0004, 32'h8, 1'b1, 16'h0, 1'b0, 16'd1, 16'd0);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        stepClock();
        checkMain("unstall", 32'hC, 32'h1300_0008, 32'hC, 1'b1, 16'hC004, 1'b1, 16'd1, 16'd0);

        stepClock();
        checkMain("run5", 32'h10, 32'h1300_000C, 32'h10, 1'b1, 16'hC008, 1'b1, 16'd1, 16'd0);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h40);
        stepClock();
        checkMain("branch", 32'h40, 32'h0, 32'h10, 1'b0, 16'hC00C, 1'b1, 16'd1, 16'd1);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        stepClock();
        checkMain("postflush", 32'h44, 32'h1300_0040, 32'h44, 1'b1, 16'h0, 1'b0, 16'd1, 16'd1);

        stepClock();
        checkMain("run8", 32'h48, 32'h1300_0044, 32'h48, 1'b1, 16'hC040, 1'b1, 16'd1, 16'd1);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80);
        stepClock();
        checkMain("stallbr", 32'h48, 32'h1300_0044, 32'h48, 1'b1, 16'h0, 1'b0, 16'd2, 16'd1);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h80);
        stepClock();
        checkMain("lateredir", 32'h80, 32'h0, 32'h48, 1'b0, 16'hC044, 1'b1, 16'd2, 16'd2);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        stepClock();
        checkMain("run11", 32'h84, 32'h1300_0080, 32'h84, 1'b1, 16'h0, 1'b0, 16'd2, 16'd2);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        stepClock();
        checkMain("midreset", 32'h0, 32'h0, 32'h0, 1'b0, 16'h0, 1'b0, 16'd0, 16'd0);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        stepClock();
        checkMain("resume1", 32'h4, 32'h1300_0000, 32'h4, 1'b1, 16'h0, 1'b0, 16'd0, 16'd0);
        stepClock();
        checkMain("resume2", 32'h8, 32'h1300_0004, 32'h8, 1'b1, 16'hC000, 1'b1, 16'd0, 16'd0);

        // Wrap/saturation instance.
        w_rst_n = 1'b0;
        stepClock();
        checkWrap("wrap.reset", 32'hFFFF_FFF8, 2'd0);
        w_rst_n = 1'b1;
        w_mux   = 1'b1;
        stepClock();
        checkWrap("wrap.c1", 32'hFFFF_FFFC, 2'd1);
        stepClock();
        checkWrap("wrap.c2", 32'h0000_0000, 2'd2);
        stepClock();
        checkWrap("wrap.c3", 32'h0000_0004, 2'd3);
        stepClock();
        checkWrap("wrap.c4", 32'h0000_0008, 2'd3);
        stepClock();
        checkWrap("wrap.c5", 32'h0000_000C, 2'd3);
        w_mux = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_stall_pipe.md
Name: fetch_stall_pipe

Overview:
- Owns the PC register, the IF/ID pipeline register and the ID/EX control register.
- Consumes the hazard unit's PC_Write / IF_ID_Write / control_mux_select outputs and turns them into register holds and bubbles.
- Also applies branch redirect/flush from ID and keeps saturating stall and flush event counters for FPGA debug readout.

Parameters:
- ADDR_W, 32, PC and branch-target width.
- INSTR_W, 32, instruction width; the NOP encoding is all zeros.
- CTRL_W, 16, width of the decoded control bundle passed into ID/EX.
- RESET_PC, 0, PC value loaded on reset.
- CNT_W, 16, width of each event counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- pc_write  in  1  1 = PC may update; 0 = hold PC.
- if_id_write  in  1  1 = IF/ID may load; 0 = hold IF/ID.
- control_mux_select  in  1  1 = insert bubble into ID/EX control.
- branch_taken  in  1  branch resolved taken in ID this cycle.
- branch_target  in  ADDR_W  redirect address.
- imem_instr  in  INSTR_W  instruction memory data for the current pc (combinational read).
- id_ctrl  in  CTRL_W  decoder control for the instruction in IF/ID.
- pc  out  ADDR_W  current fetch address (registered).
- if_id_instr  out  INSTR_W  IF/ID instruction.
- if_id_pc4  out  ADDR_W  IF/ID pc+4.
- if_id_valid  out  1  IF/ID holds a real instruction.
- id_ex_ctrl  out  CTRL_W  ID/EX control.
- id_ex_valid  out  1  ID/EX holds a real instruction.
- stall_count  out  CNT_W  cycles with control_mux_select=1, saturating.
- flush_count  out  CNT_W  accepted branch redirects, saturating.

Behaviour:
- All state updates on the rising clk edge; all outputs are registered, with no combinational input-to-output path.
- Reset (rst_n=0 at an edge) overrides everything:
  - pc=RESET_PC.
  - if_id_instr=0, if_id_pc4=0, if_id_valid=0.
  - id_ex_ctrl=0, id_ex_valid=0.
  - stall_count=0, flush_count=0.
- Reset takes effect at the first edge it is seen, including mid-stall or mid-flush.
- Branch acceptance: accept = branch_taken & if_id_valid & ~control_mux_select.
  - A stalled ID instruction cannot redirect, because its operands are not ready.
- PC update priority is accept > pc_write > hold:
  - accept: pc <= branch_target.
  - else pc_write=1: pc <= pc+4, modulo 2^ADDR_W (0xFFFFFFFC wraps to 0x00000000).
  - else: pc holds.
- IF/ID update priority is accept > if_id_write > hold:
  - accept: flush; if_id_instr<=0, if_id_valid<=0, if_id_pc4 holds.
  - else if_id_write=1: if_id_instr<=imem_instr, if_id_pc4<=pc+4, if_id_valid<=1.
  - else: all three hold.
- ID/EX control:
  - If control_mux_select=1 or if_id_valid=0: id_ex_ctrl<=0, id_ex_valid<=0.
  - Else: id_ex_ctrl<=id_ctrl, id_ex_valid<=1.
  - A branch in ID advances into ID/EX normally when accepted (not a bubble).
- pc_write and if_id_write are honoured independently. No consistency is enforced between them or with control_mux_select; the hazard unit is responsible for that.
- stall_count increments on each edge with control_mux_select=1 and sticks at 2^CNT_W-1.
- flush_count increments on each accept and sticks at 2^CNT_W-1.
- Latency:
  - Instruction at pc appears in if_id_instr 1 cycle later.
  - Its control appears in id_ex_ctrl 2 cycles after fetch, absent stalls.
  - Redirect: branch_target is on pc 1 cycle after branch_taken is sampled.
  - Net cost is exactly 1 flushed slot.
- First cycle after reset:
  - pc=RESET_PC, IF/ID invalid, so one bubble enters ID/EX.
  - branch_taken is ignored because if_id_valid=0.

Test Plan:
- Reset then free-run with pc_write=if_id_write=1, mux_sel=0, imem_instr=pc-derived:
  - pc sequence 0,4,8,12.
  - if_id_instr lags pc by 1 cycle, if_id_pc4 = fetched pc+4.
  - id_ex_valid first 1 at cycle 2.
- Load-use stall: at pc=8 drive pc_write=0, if_id_write=0, mux_sel=1 for one cycle.
  - pc stays 8 and IF/ID holds the instruction fetched at 4.
  - id_ex_ctrl=0 with id_ex_valid=0 for that slot; stall_count=1.
  - Next cycle the held instruction's id_ctrl enters ID/EX.
- Branch: with IF/ID valid and pc=0x10, branch_taken=1, target=0x40.
  - Next edge: pc=0x40, if_id_valid=0, if_id_instr=0, flush_count=1.
  - The following cycle id_ex_valid=0.
- Simultaneous stall and branch: mux_sel=1, pc_write=0, branch_taken=1, target=0x80.
  - pc holds and IF/ID holds; flush_count unchanged; stall_count+1.
  - Deassert stall with branch_taken still 1: redirect to 0x80 occurs.
- Wrap and saturation: RESET_PC=0xFFFFFFF8, CNT_W=2, mux_sel held 1 for 5 cycles with pc_write=1.
  - pc goes 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
  - stall_count reaches 3 and stays 3.
- Reset mid-stall: rst_n=0 for one edge while mux_sel=1 and counters are nonzero.
  - All outputs equal reset values at that edge; normal fetch resumes from RESET_PC after rst_n=1.
